// File: rtl/apb_slave_regs_if.sv
// APB4 bus bundle between a requester and the apb_slave_regs completer.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

interface apb_slave_regs_if #(
  parameter int ADDR_WIDTH = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `APB_DATA_WIDTH
);
  logic                    psel;
  logic                    penable;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regs.sv
// APB4 completer with a byte-strobed register bank, programmable wait
// states, secure-region protection and pslverr generation.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_regs #(
  parameter int          ADDR_WIDTH  = `APB_ADDR_WIDTH,
  parameter int          DATA_WIDTH  = `APB_DATA_WIDTH,
  parameter int          REG_NUM     = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
  parameter int          SECURE_BASE = 4
) (
  input logic              clk,
  input logic              rstn,
  apb_slave_regs_if.slave  apb
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AL     = $clog2(STRB_W);
  // Byte-offset bits inside one word; nonzero means a misaligned access.
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << AL) - 1);
  localparam logic [DATA_WIDTH-1:0] ID_RESET = ID_VALUE[DATA_WIDTH-1:0];

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_strb;
  logic                  r_nonsec;
  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];

  logic                  w_setup;
  logic                  w_ready;
  logic                  w_complete;
  logic                  w_err;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_setup    = (r_state == S_IDLE) && apb.psel && !apb.penable;
  assign w_ready    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_complete = w_ready && apb.psel && apb.penable;
  assign w_idx      = r_addr >> AL;

  // Error decode works purely on the values captured in the setup phase.
  assign w_err = ((r_addr & LOW_MASK) != '0)
              || (w_idx >= ADDR_WIDTH'(REG_NUM))
              || (r_nonsec && (w_idx >= ADDR_WIDTH'(SECURE_BASE)))
              || (r_write && (w_idx == '0))
              || (!r_write && (r_strb != '0));

  assign w_wr_en = w_complete && r_write && !w_err;

  // State register: FSM state and wait-state down-counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_setup)
        r_cnt <= 4'(WAIT_CYCLES);
      else if ((r_state == S_ACCESS) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture the request at setup so bus changes during access are ignored
  always_ff @(posedge clk) begin
    if (w_setup) begin
      r_addr   <= apb.paddr;
      r_write  <= apb.pwrite;
      r_wdata  <= apb.pwdata;
      r_strb   <= apb.pstrb;
      r_nonsec <= apb.pprot[1];
    end
  end

  // Next-state: setup opens an access; completion or dropped psel closes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_setup) w_state_nxt = S_ACCESS;
      S_ACCESS: if (!apb.psel || w_complete) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Read mux over the register bank, selected by the latched index
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < REG_NUM; k++)
      if (w_idx == ADDR_WIDTH'(k)) w_rdata = r_regs[k];
  end

  // Outputs: response only in the ready cycle, data only for clean reads
  always_comb begin
    apb.pready  = w_ready;
    apb.pslverr = w_ready && w_err;
    apb.prdata  = (w_ready && !r_write && !w_err) ? w_rdata : '0;
  end

  // Register bank: reg 0 holds the ID, others take strobed byte writes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < REG_NUM; k++)
        r_regs[k] <= (k == 0) ? ID_RESET : '0;
    end else if (w_wr_en) begin
      for (int k = 1; k < REG_NUM; k++)
        if (w_idx == ADDR_WIDTH'(k))
          for (int b = 0; b < STRB_W; b++)
            if (r_strb[b]) r_regs[k][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: three instances with 0, 2 and 3
// wait states share one driven bus, only the selected one sees psel.
module tb_apb_slave_regs;
  logic        clk = 1'b0;
  logic        rstn;
  int          sel;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] o_rd  [3];
  logic        o_rdy [3];
  logic        o_err [3];

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mdl [3][8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.psel    = psel && (sel == g);
    assign bus.penable = penable;
    assign bus.paddr   = paddr;
    assign bus.pwrite  = pwrite;
    assign bus.pwdata  = pwdata;
    assign bus.pstrb   = pstrb;
    assign bus.pprot   = pprot;
    assign o_rd[g]     = bus.prdata;
    assign o_rdy[g]    = bus.pready;
    assign o_err[g]    = bus.pslverr;
    apb_slave_regs #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(8),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3)),
      .ID_VALUE(32'hA5B0_0001), .SECURE_BASE(4)
    ) u_dut (
      .clk (clk),
      .rstn(rstn),
      .apb (bus)
    );
  end

  function automatic int exp_waits(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 8; k++)
        mdl[d][k] = (k == 0) ? 32'hA5B0_0001 : 32'h0;
  endtask

  // One full APB transfer on instance d, checked against the model.
  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] data, input logic [3:0] st, input logic [2:0] pr);
    int          waits;
    int          idx;
    logic        e;
    logic [31:0] exp_rd;
    idx = int'(a >> 2);
    e = (a[1:0] != 2'b00) || (idx >= 8) || (pr[1] && idx >= 4)
        || (w && idx == 0) || (!w && st != 4'b0000);
    @(negedge clk);
    sel = d; psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = data; pstrb = st; pprot = pr;
    @(negedge clk);
    penable = 1'b1;
    // scramble inputs that the slave must ignore during access
    paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
    #1;
    waits = 0;
    while (!o_rdy[d] && waits < 20) begin
      chk("wait_pslverr", {31'b0, o_err[d]}, 32'h0);
      chk("wait_prdata", o_rd[d], 32'h0);
      waits++;
      @(negedge clk); #1;
    end
    chk("wait_count", 32'(waits), 32'(exp_waits(d)));
    chk("pslverr", {31'b0, o_err[d]}, {31'b0, e});
    exp_rd = (!w && !e) ? mdl[d][idx] : 32'h0;
    chk("prdata", o_rd[d], exp_rd);
    if (w && !e)
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
    chk("idle_pready", {31'b0, o_rdy[sel]}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; sel = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", {31'b0, o_rdy[d]}, 32'h0);
      chk("rst_pslverr", {31'b0, o_err[d]}, 32'h0);
      chk("rst_prdata", o_rd[d], 32'h0);
    end
    rstn = 1'b1;

    // ID register read, zero wait
    xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("id_value", o_rd[0], 32'hA5B0_0001);
    bus_idle();

    // Strobed write and readback, zero and three wait states
    xfer(0, 32'h4, 1'b1, 32'h1122_3344, 4'b0101, 3'b000);
    xfer(0, 32'h4, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("strb_rd_w0", o_rd[0], 32'h0022_0044);
    bus_idle();
    xfer(2, 32'h4, 1'b1, 32'h1122_3344, 4'b0101, 3'b000);
    bus_idle();
    xfer(2, 32'h4, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("strb_rd_w3", o_rd[2], 32'h0022_0044);
    bus_idle();

    // Error cases
    xfer(0, 32'h0,  1'b1, 32'hFFFF_FFFF, 4'hF, 3'b000);
    xfer(0, 32'h0,  1'b0, 32'h0, 4'h0, 3'b000);
    xfer(0, 32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
    xfer(0, 32'h6,  1'b0, 32'h0, 4'h0, 3'b000);
    xfer(0, 32'h10, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b010);
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("secure_blocked", o_rd[0], 32'h0);
    xfer(0, 32'h10, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000);
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("secure_ok", o_rd[0], 32'hCAFE_F00D);
    xfer(0, 32'h8,  1'b0, 32'h0, 4'b0001, 3'b000);
    bus_idle();

    // Abort: drop psel after one wait cycle on the 2-wait instance
    @(negedge clk);
    sel = 1; psel = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 3'b000;
    @(negedge clk); penable = 1'b1; #1;
    chk("abort_wait1", {31'b0, o_rdy[1]}, 32'h0);
    @(negedge clk); psel = 1'b0; penable = 1'b0; #1;
    chk("abort_wait2", {31'b0, o_rdy[1]}, 32'h0);
    @(negedge clk); #1;
    chk("abort_after", {31'b0, o_rdy[1]}, 32'h0);
    xfer(1, 32'hC, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("abort_nowrite", o_rd[1], 32'h0);
    bus_idle();

    // Reset during a wait state on the 3-wait instance
    xfer(2, 32'h8, 1'b1, 32'hAAAA_5555, 4'hF, 3'b000);
    bus_idle();
    @(negedge clk);
    sel = 2; psel = 1'b1; penable = 1'b0; paddr = 32'h8; pwrite = 1'b1;
    pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b000;
    @(negedge clk); penable = 1'b1; #1;
    chk("rstw_wait", {31'b0, o_rdy[2]}, 32'h0);
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); #1;
    chk("rstw_pready", {31'b0, o_rdy[2]}, 32'h0);
    rstn = 1'b1; psel = 1'b0; penable = 1'b0;
    mdl_reset();
    repeat (4) @(negedge clk);
    #1;
    chk("rstw_idle", {31'b0, o_rdy[2]}, 32'h0);
    xfer(2, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("rstw_nowrite", o_rd[2], 32'h0);
    bus_idle();

    // Back-to-back write then read
    xfer(0, 32'h8, 1'b1, 32'h0000_0055, 4'hF, 3'b000);
    xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000);
    chk("b2b_read", o_rd[0], 32'h0000_0055);
    bus_idle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int          d, idx;
      logic [31:0] a;
      logic        w;
      logic [3:0]  st;
      logic [2:0]  pr;
      d   = $urandom_range(0, 2);
      idx = $urandom_range(0, 9);
      a   = 32'(idx * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      w   = 1'($urandom_range(0, 1));
      if (w) st = 4'($urandom);
      else   st = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      pr  = 3'($urandom);
      pr[1] = ($urandom_range(0, 3) == 0);
      xfer(d, a, w, $urandom, st, pr);
      if ($urandom_range(0, 1) == 1) begin
        bus_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    bus_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB4 completer (slave) with a byte-strobed register bank.
- It is the responder end of the transfers driven through the testbench-to-master interface: the APB master's psel/penable phases terminate here.
- Provides configurable wait states, protection checking and pslverr generation.
- One instance per slave device. Used as the DUT-side target for master-interface tests and as a reusable peripheral register file.

Parameters:
- ADDR_WIDTH, `APB_ADDR_WIDTH: address bus width.
- DATA_WIDTH, `APB_DATA_WIDTH: data bus width (8, 16 or 32).
- REG_NUM, 8: number of word registers; index = paddr[..:log2(DATA_WIDTH/8)].
- WAIT_CYCLES, 0: pready-low cycles inserted in every access phase (0..15).
- ID_VALUE, 32'hA5B0_0001: reset/constant value of read-only register 0, truncated to DATA_WIDTH.
- SECURE_BASE, 4: registers with index >= SECURE_BASE reject non-secure access (pprot[1]=1).

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: synchronous active-low reset.
- psel, input, 1: slave select.
- penable, input, 1: access phase.
- paddr, input, ADDR_WIDTH: byte address.
- pwrite, input, 1: 1=write, 0=read.
- pwdata, input, DATA_WIDTH: write data.
- pstrb, input, DATA_WIDTH/8: write byte strobes.
- pprot, input, 3: protection; bit1=1 means non-secure.
- prdata, output, DATA_WIDTH: read data.
- pready, output, 1: transfer complete.
- pslverr, output, 1: transfer error.

Behaviour:
- Reset (rstn=0 at clk edge): state=IDLE, wait counter=0, reg[0]=ID_VALUE, reg[1..REG_NUM-1]=0. Outputs: pready=0, pslverr=0, prdata=0. A reset mid-transfer aborts it with no register update.
- FSM states: IDLE, ACCESS.
- IDLE:
  - psel=1 & penable=0 (setup): latch paddr, pwrite, pwdata, pstrb, pprot; load cnt=WAIT_CYCLES; go to ACCESS.
  - Any other input: stay in IDLE.
- ACCESS:
  - pready is combinational: (state==ACCESS) & (cnt==0). While cnt!=0, decrement cnt each cycle.
  - Completion cycle: psel & penable & pready. Return to IDLE. The next setup may occur in the following cycle, giving back-to-back transfers with no dead cycle.
  - psel=0 before completion: abort, return to IDLE, no write, no response.
  - Latched values are used; input changes during ACCESS are ignored.
- Latency: WAIT_CYCLES=0 completes in the first access cycle (2-cycle transfer). Otherwise completion is WAIT_CYCLES cycles later.
- Error evaluation on latched values (err = OR of all):
  - misaligned: low address bits != 0.
  - out of range: index >= REG_NUM.
  - secure violation: pprot[1]=1 and index >= SECURE_BASE.
  - write to reg 0.
  - read with pstrb != 0.
- pslverr = err & pready; it is 0 in every other cycle.
- Write at completion with err=0: for each byte b, reg[idx].byte[b] <= pstrb[b] ? pwdata.byte[b] : unchanged. pstrb=0 is a legal no-op write.
- Write with err=1: no state change.
- prdata: equals reg[idx] only in a read completion cycle with err=0. Otherwise 0, including error reads, writes and wait cycles.
- Register update and read in the same completion: not possible (one transfer at a time). A read immediately following a write returns the new value.

Test Plan:
- Reset, then read idx0 (paddr=0x0), WAIT_CYCLES=0 -> pready=1 in first access cycle, prdata=32'hA5B0_0001, pslverr=0.
- Write 0x1122_3344 to 0x4 with pstrb=4'b0101, prior value 0 -> readback 0x0022_0044. Repeat with WAIT_CYCLES=3 -> pready low for exactly 3 access cycles, then high for 1.
- Error cases, each -> pslverr=1 with pready, prdata=0, registers unchanged:
  - write to 0x0;
  - read 0x20 (idx8, out of range);
  - read 0x6 (misaligned);
  - write 0x10 with pprot=3'b010.
- Same write to 0x10 with pprot=3'b000 -> success; readback matches.
- Read of 0x8 with pstrb=4'b0001 -> pslverr=1.
- Abort: WAIT_CYCLES=2, write 0xDEAD_BEEF to 0xC, drop psel after 1 wait cycle -> no pready; read 0xC returns 0.
- Reset asserted during a wait state -> FSM returns to IDLE, pready=0, no write.
- Back-to-back: write 0x8=0x55, then immediately read 0x8 (setup in the cycle after completion) -> prdata=0x55, no idle cycle needed.
